// File: rtl/fpu_div_sequencer.sv
// Sequences one FP divide: latches operands, handshakes them into the divider, collects the quotient.
// Optional divider watchdog enabled by defining FDIV_TIMEOUT_EN; latency start->done is 4 cycles minimum.
module fpu_div_sequencer #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  input  logic [4:0]  rd_in,
  input  logic        flush,
  output logic        busy,
  output logic        done,
  output logic [31:0] result,
  output logic [4:0]  rd_out,
  output logic        timeout_err,
  output logic [31:0] div_a,
  output logic [31:0] div_b,
  output logic        div_a_stb,
  output logic        div_b_stb,
  input  logic        div_a_ack,
  input  logic        div_b_ack,
  input  logic [31:0] div_z,
  input  logic        div_z_stb,
  output logic        div_z_ack
);

  typedef enum logic [2:0] {IDLE, SEND, WAIT_Z, ACK_Z, DONE} state_t;

  state_t      state_q, state_d;
  logic [31:0] div_a_q, div_a_d, div_b_q, div_b_d, result_q, result_d;
  logic [4:0]  tag_q, tag_d, rd_out_q, rd_out_d;
  logic        a_stb_q, a_stb_d, b_stb_q, b_stb_d;
  logic        drop_q, drop_d, tmo_q, tmo_d;
  logic        tmo_hit;

`ifdef FDIV_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt_q, cnt_d;

  assign tmo_hit = (state_q == WAIT_Z) && !div_z_stb && (cnt_q == CW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    cnt_d = '0;
    if (state_q == WAIT_Z && !div_z_stb && !tmo_hit) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
  assign tmo_hit = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      div_a_q  <= '0;
      div_b_q  <= '0;
      result_q <= '0;
      tag_q    <= '0;
      rd_out_q <= '0;
      a_stb_q  <= 1'b0;
      b_stb_q  <= 1'b0;
      drop_q   <= 1'b0;
      tmo_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      div_a_q  <= div_a_d;
      div_b_q  <= div_b_d;
      result_q <= result_d;
      tag_q    <= tag_d;
      rd_out_q <= rd_out_d;
      a_stb_q  <= a_stb_d;
      b_stb_q  <= b_stb_d;
      drop_q   <= drop_d;
      tmo_q    <= tmo_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = SEND;
      // An operand is finished once its strobe has dropped or its ack is present now.
      SEND:    if ((!a_stb_q || div_a_ack) && (!b_stb_q || div_b_ack)) state_d = WAIT_Z;
      WAIT_Z:  if (div_z_stb) state_d = ACK_Z;
               else if (tmo_hit) state_d = DONE;
      ACK_Z:   state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    div_a_d  = div_a_q;
    div_b_d  = div_b_q;
    result_d = result_q;
    tag_d    = tag_q;
    rd_out_d = rd_out_q;
    a_stb_d  = a_stb_q;
    b_stb_d  = b_stb_q;
    drop_d   = drop_q;
    tmo_d    = tmo_q;
    case (state_q)
      IDLE: if (start) begin
        div_a_d = op_a;
        div_b_d = op_b;
        tag_d   = rd_in;
        a_stb_d = 1'b1;
        b_stb_d = 1'b1;
        drop_d  = 1'b0;
        tmo_d   = 1'b0;
      end
      SEND: begin
        if (div_a_ack) a_stb_d = 1'b0;
        if (div_b_ack) b_stb_d = 1'b0;
      end
      WAIT_Z: if (div_z_stb) begin
        result_d = div_z;
        rd_out_d = tag_q;
      end else if (tmo_hit) begin
        result_d = 32'h7FC0_0000;
        rd_out_d = tag_q;
        tmo_d    = 1'b1;
      end
      default: ;
    endcase
    // A killed divide still finishes its handshake; only the done pulse is withheld.
    if (flush && (state_q == SEND || state_q == WAIT_Z || state_q == ACK_Z)) drop_d = 1'b1;
  end

  always_comb begin
    busy        = (state_q != IDLE);
    done        = (state_q == DONE) && !drop_q;
    timeout_err = (state_q == DONE) && !drop_q && tmo_q;
    div_z_ack   = (state_q == ACK_Z);
    div_a_stb   = a_stb_q;
    div_b_stb   = b_stb_q;
    div_a       = div_a_q;
    div_b       = div_b_q;
    result      = result_q;
    rd_out      = rd_out_q;
  end

endmodule

// File: tb/tb_fpu_div_sequencer.sv
// Directed bench for fpu_div_sequencer; the divider is played by hand in each scenario task.
module tb_fpu_div_sequencer;
  logic        clk = 1'b0;
  logic        rst, start, flush;
  logic [31:0] op_a, op_b, div_z;
  logic [4:0]  rd_in;
  logic        div_a_ack, div_b_ack, div_z_stb;
  logic        busy, done, timeout_err, div_a_stb, div_b_stb, div_z_ack;
  logic [31:0] result, div_a, div_b;
  logic [4:0]  rd_out;

  int tests_run = 0;
  int tests_failed = 0;

  fpu_div_sequencer #(.TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .rst(rst), .start(start), .op_a(op_a), .op_b(op_b), .rd_in(rd_in),
    .flush(flush), .busy(busy), .done(done), .result(result), .rd_out(rd_out),
    .timeout_err(timeout_err), .div_a(div_a), .div_b(div_b),
    .div_a_stb(div_a_stb), .div_b_stb(div_b_stb), .div_a_ack(div_a_ack),
    .div_b_ack(div_b_ack), .div_z(div_z), .div_z_stb(div_z_stb), .div_z_ack(div_z_ack)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
    start = 1'b1; op_a = a; op_b = b; rd_in = rd;
    tick;
    start = 1'b0; op_a = '1; op_b = '1; rd_in = '1;
  endtask

  task automatic test_reset;
    rst = 1'b0; start = 0; flush = 0; op_a = 0; op_b = 0; rd_in = 0;
    div_a_ack = 0; div_b_ack = 0; div_z_stb = 0; div_z = 0;
    tick;
    tests_run++;
    if ({busy, done, timeout_err, div_a_stb, div_b_stb, div_z_ack} !== 6'b0) begin
      tests_failed++;
      $display("FAIL reset_ctrl: got %b want 000000", {busy, done, timeout_err, div_a_stb, div_b_stb, div_z_ack});
    end
    tests_run++;
    if ({result, rd_out, div_a, div_b} !== 101'b0) begin
      tests_failed++;
      $display("FAIL reset_data: result=%h rd_out=%0d div_a=%h div_b=%h want all 0", result, rd_out, div_a, div_b);
    end
    rst = 1'b1;
    tick;
  endtask

  task automatic test_basic(input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd,
                            input logic [31:0] z);
    issue(a, b, rd);
    tests_run++;
    if ({busy, div_a_stb, div_b_stb, done, div_a, div_b} !== {4'b1110, a, b}) begin
      tests_failed++;
      $display("FAIL basic_send: busy=%b stb=%b%b done=%b div_a=%h div_b=%h want 1 11 0 %h %h",
               busy, div_a_stb, div_b_stb, done, div_a, div_b, a, b);
    end
    div_a_ack = 1; div_b_ack = 1;
    tick;
    div_a_ack = 0; div_b_ack = 0;
    tests_run++;
    if ({div_a_stb, div_b_stb, done, busy} !== 4'b0001) begin
      tests_failed++;
      $display("FAIL basic_wait: stb=%b%b done=%b busy=%b want 00 0 1", div_a_stb, div_b_stb, done, busy);
    end
    div_z_stb = 1; div_z = z;
    tick;
    div_z_stb = 0; div_z = '0;
    tests_run++;
    if ({div_z_ack, done} !== 2'b10) begin
      tests_failed++;
      $display("FAIL basic_ackz: div_z_ack=%b done=%b want 1 0", div_z_ack, done);
    end
    tick;
    tests_run++;
    if ({done, timeout_err, div_z_ack, result, rd_out} !== {3'b100, z, rd}) begin
      tests_failed++;
      $display("FAIL basic_done: done=%b terr=%b zack=%b result=%h rd_out=%0d want 1 0 0 %h %0d",
               done, timeout_err, div_z_ack, result, rd_out, z, rd);
    end
    tick;
    tests_run++;
    if ({done, busy, result, rd_out} !== {2'b00, z, rd}) begin
      tests_failed++;
      $display("FAIL basic_idle: done=%b busy=%b result=%h rd_out=%0d want 0 0 %h %0d",
               done, busy, result, rd_out, z, rd);
    end
  endtask

  task automatic test_ack_order;
    issue(32'h3F800000, 32'h40000000, 5'd12);
    div_a_ack = 1;
    tick; // +2
    div_a_ack = 0;
    tests_run++;
    if ({div_a_stb, div_b_stb, div_b} !== {2'b01, 32'h40000000}) begin
      tests_failed++;
      $display("FAIL order_a_drop: stb=%b%b div_b=%h want 01 40000000", div_a_stb, div_b_stb, div_b);
    end
    div_z_stb = 1; div_z = 32'hDEADBEEF;
    tick; // +3
    div_z_stb = 0;
    tests_run++;
    if ({div_z_ack, div_b_stb} !== 2'b01) begin
      tests_failed++;
      $display("FAIL order_stray_z: div_z_ack=%b div_b_stb=%b want 0 1", div_z_ack, div_b_stb);
    end
    tick; // +4
    tick; // +5
    div_b_ack = 1;
    tests_run++;
    if ({div_b_stb, div_z_ack, div_b} !== {2'b10, 32'h40000000}) begin
      tests_failed++;
      $display("FAIL order_b_hold: div_b_stb=%b zack=%b div_b=%h want 1 0 40000000", div_b_stb, div_z_ack, div_b);
    end
    tick; // +6 WAIT_Z
    div_b_ack = 0;
    tests_run++;
    if ({div_a_stb, div_b_stb, busy, div_z_ack} !== 4'b0010) begin
      tests_failed++;
      $display("FAIL order_wait: stb=%b%b busy=%b zack=%b want 00 1 0", div_a_stb, div_b_stb, busy, div_z_ack);
    end
    div_z_stb = 1; div_z = 32'h3F000000;
    tick; // +7
    div_z_stb = 0;
    tests_run++;
    if (div_z_ack !== 1'b1) begin
      tests_failed++;
      $display("FAIL order_ackz: div_z_ack=%b want 1", div_z_ack);
    end
    tick; // +8
    tests_run++;
    if ({done, result, rd_out} !== {1'b1, 32'h3F000000, 5'd12}) begin
      tests_failed++;
      $display("FAIL order_done: done=%b result=%h rd_out=%0d want 1 3f000000 12", done, result, rd_out);
    end
    tick;
  endtask

  task automatic test_back_to_back;
    int pulses;
    issue(32'h40800000, 32'h40000000, 5'd3);
    start = 1; op_a = 32'h41200000; op_b = 32'h3F800000; rd_in = 5'd9;
    div_a_ack = 1; div_b_ack = 1;
    tick;
    start = 0; div_a_ack = 0; div_b_ack = 0;
    tests_run++;
    if ({busy, div_a, div_b} !== {1'b1, 32'h40800000, 32'h40000000}) begin
      tests_failed++;
      $display("FAIL b2b_latch: busy=%b div_a=%h div_b=%h want 1 40800000 40000000", busy, div_a, div_b);
    end
    div_z_stb = 1; div_z = 32'h40000000;
    tick;
    div_z_stb = 0;
    tick;
    tests_run++;
    if ({done, rd_out, result} !== {1'b1, 5'd3, 32'h40000000}) begin
      tests_failed++;
      $display("FAIL b2b_done: done=%b rd_out=%0d result=%h want 1 3 40000000", done, rd_out, result);
    end
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      tick;
      if (done) pulses++;
    end
    tests_run++;
    if ({pulses, busy} !== {32'd0, 1'b0}) begin
      tests_failed++;
      $display("FAIL b2b_single: extra_done=%0d busy=%b want 0 0", pulses, busy);
    end
  endtask

  task automatic test_flush;
    int pulses;
    issue(32'h40000000, 32'h40000000, 5'd4);
    div_a_ack = 1; div_b_ack = 1;
    tick;
    div_a_ack = 0; div_b_ack = 0;
    flush = 1;
    tick;
    flush = 0;
    tests_run++;
    if ({busy, div_z_ack} !== 2'b10) begin
      tests_failed++;
      $display("FAIL flush_wait: busy=%b zack=%b want 1 0", busy, div_z_ack);
    end
    div_z_stb = 1; div_z = 32'h12345678;
    tick;
    div_z_stb = 0;
    tests_run++;
    if ({div_z_ack, done} !== 2'b10) begin
      tests_failed++;
      $display("FAIL flush_ackz: div_z_ack=%b done=%b want 1 0", div_z_ack, done);
    end
    pulses = 0;
    for (int i = 0; i < 4; i++) begin
      tick;
      if (done || div_z_ack) pulses++;
    end
    tests_run++;
    if ({pulses, busy} !== {32'd0, 1'b0}) begin
      tests_failed++;
      $display("FAIL flush_drop: done_or_zack=%0d busy=%b want 0 0", pulses, busy);
    end
  endtask

  task automatic test_flush_with_start;
    flush = 1;
    issue(32'h41000000, 32'h40800000, 5'd17);
    flush = 0;
    div_a_ack = 1; div_b_ack = 1;
    tick;
    div_a_ack = 0; div_b_ack = 0; div_z_stb = 1; div_z = 32'h40000000;
    tick;
    div_z_stb = 0;
    tick;
    tests_run++;
    if ({done, rd_out, result} !== {1'b1, 5'd17, 32'h40000000}) begin
      tests_failed++;
      $display("FAIL flush_start: done=%b rd_out=%0d result=%h want 1 17 40000000", done, rd_out, result);
    end
    tick;
  endtask

  task automatic test_timeout;
    int seen;
    int low;
    issue(32'h40000000, 32'h00000000, 5'd2);
    div_a_ack = 1; div_b_ack = 1;
    tick; // +2
    div_a_ack = 0; div_b_ack = 0;
`ifdef FDIV_TIMEOUT_EN
    seen = -1;
    for (int c = 2; c <= 30 && seen < 0; c++) begin
      if (done) seen = c;
      else tick;
    end
    tests_run++;
    if ({seen, result, timeout_err, rd_out} !== {32'd10, 32'h7FC00000, 1'b1, 5'd2}) begin
      tests_failed++;
      $display("FAIL timeout_done: at=+%0d result=%h terr=%b rd_out=%0d want +10 7fc00000 1 2",
               seen, result, timeout_err, rd_out);
    end
    tick;
    low = busy ? 0 : 1;
`else
    seen = 0;
    low = 0;
    for (int c = 2; c < 22; c++) begin
      if (!busy || done || timeout_err) low++;
      tick;
    end
    rst = 0;
    tick;
    rst = 1;
    tick;
    seen = busy ? 0 : 1;
`endif
    tests_run++;
    if ({low, seen} !== {32'd1, 32'd10}
`ifndef FDIV_TIMEOUT_EN
        && {low, seen} !== {32'd0, 32'd1}
`endif
       ) begin
      tests_failed++;
      $display("FAIL timeout_wait: bad_cycles_or_idle=%0d recovered=%0d", low, seen);
    end
  endtask

  task automatic test_reset_mid;
    int pulses;
    issue(32'h40000000, 32'h3F800000, 5'd30);
    tests_run++;
    if ({busy, div_a_stb, div_b_stb} !== 3'b111) begin
      tests_failed++;
      $display("FAIL rstmid_send: busy=%b stb=%b%b want 1 11", busy, div_a_stb, div_b_stb);
    end
    #2 rst = 0;
    #1;
    tests_run++;
    if ({busy, div_a_stb, div_b_stb, done} !== 4'b0000) begin
      tests_failed++;
      $display("FAIL rstmid_async: busy=%b stb=%b%b done=%b want 0 00 0", busy, div_a_stb, div_b_stb, done);
    end
    tick;
    tick;
    rst = 1;
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      tick;
      if (done || busy) pulses++;
    end
    tests_run++;
    if (pulses !== 0) begin
      tests_failed++;
      $display("FAIL rstmid_quiet: busy_or_done_cycles=%0d want 0", pulses);
    end
  endtask

  initial begin
    test_reset;
    test_basic(32'h408ccccd, 32'h400ccccd, 5'd7, 32'h40000000);
    test_ack_order;
    test_back_to_back;
    test_flush;
    test_basic(32'h40400000, 32'h40000000, 5'd21, 32'h3FC00000);
    test_flush_with_start;
    test_timeout;
    test_reset_mid;
    test_basic(32'hC0800000, 32'h40000000, 5'd31, 32'hC0000000);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule

// File: doc/fpu_div_sequencer.md
FPU_DIV_SEQUENCER -- requirements
Module: fpu_div_sequencer

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 64, meaning WAIT_Z cycles allowed before abort; only used with FDIV_TIMEOUT_EN.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  single-cycle request from the pipeline FP execute stage.
REQ-005 op_a / op_b  input  32 each  IEEE-754 single-precision dividend / divisor, valid with start.
REQ-006 rd_in  input  5  destination register tag, valid with start.
REQ-007 flush  input  1  pipeline kill of the in-flight divide.
REQ-008 busy  output  1  sequencer not IDLE.
REQ-009 done  output  1  one-cycle result-valid pulse.
REQ-010 result  output  32  quotient; rd_out  output  5  tag returned with result.
REQ-011 timeout_err  output  1  qualifies done when the divider failed to answer.
REQ-012 div_a / div_b  output  32 each  operands to divider; div_a_stb / div_b_stb  output  1 each; div_a_ack / div_b_ack  input  1 each.
REQ-013 div_z  input  32; div_z_stb  input  1; div_z_ack  output  1  divider result channel.

Function
REQ-014 States SHALL be IDLE, SEND, WAIT_Z, ACK_Z, DONE.
REQ-015 IDLE + start: latch op_a, op_b, rd_in into div_a, div_b, tag register; go to SEND; div_a_stb and div_b_stb high from the next cycle.
REQ-016 start while busy SHALL be ignored, no latch, no state change.
REQ-017 SEND: each stb held high until its own ack is sampled high, then cleared next cycle independently; acks may arrive same cycle or any order.
REQ-018 SEND -> WAIT_Z in the cycle after both acks have been seen; div_a/div_b held stable while their stb is high.
REQ-019 WAIT_Z + div_z_stb: capture div_z into result, go to ACK_Z.
REQ-020 ACK_Z: div_z_ack high for exactly one cycle, then DONE.
REQ-021 DONE: done high one cycle with result and rd_out valid, then IDLE; result/rd_out hold until next capture.
REQ-022 Minimum latency: start in cycle n, zero-wait divider (acks at n+1, z_stb at n+2) -> done at n+4.
REQ-023 flush while busy SHALL set a drop flag; sequencer completes the divider handshake (SEND, WAIT_Z, ACK_Z) so the divider is not left mid-transaction, and suppresses done in DONE.
REQ-024 flush in IDLE or DONE SHALL have no effect; flush and start in the same IDLE cycle: start accepted, drop flag clear.
REQ-025 div_z_stb outside WAIT_Z SHALL be ignored.

Reset
REQ-026 On rst low, asynchronously: state IDLE; busy, done, timeout_err, div_a_stb, div_b_stb, div_z_ack = 0; result, rd_out, div_a, div_b = 0; drop flag and timeout counter cleared.
REQ-027 Reset mid-operation aborts immediately with no done pulse; release resumes in IDLE.

Configuration
REQ-028 With FDIV_TIMEOUT_EN defined: counter increments each WAIT_Z cycle; reaching TIMEOUT_CYCLES without div_z_stb forces result = 32'h7FC00000, timeout_err = 1 with done (unless dropped), state DONE.
REQ-029 Without FDIV_TIMEOUT_EN: no counter; WAIT_Z waits indefinitely; timeout_err tied 0.

Verification
REQ-030 start, op_a=32'h408ccccd, op_b=32'h400ccccd, rd_in=5'd7, zero-wait model -> done 4 cycles later, result=32'h40000000, rd_out=7, timeout_err=0.
REQ-031 div_a_ack at +1, div_b_ack at +5 -> div_a_stb low from +2, div_b_stb high through +5, WAIT_Z entered at +6.
REQ-032 Second start one cycle after first -> ignored; only one done, carrying first tag.
REQ-033 flush while in WAIT_Z -> div_z_ack still pulses once on div_z_stb, no done, busy low afterwards, next start behaves normally.
REQ-034 FDIV_TIMEOUT_EN, TIMEOUT_CYCLES=8, divider never raises div_z_stb -> done with result=32'h7FC00000, timeout_err=1; without macro busy stays high.
REQ-035 rst low during SEND -> all stb and busy low asynchronously, no done after release.
